// File: rtl/mux_rr_nw_pkg.sv
// Shared constants, state encoding and width helper for the
// round-robin / fixed-priority registered multiplexer.
package mux_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Channel-index width; never below one bit.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux_rr_nw_rr_arbiter.sv
// Combinational arbiter: rotating search from last_g+1 (mod NCH)
// or lowest-index-wins when mode is set.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int NCH = 4,
    localparam int CW  = clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  last_g,
    input  logic           mode,
    output logic [NCH-1:0] grant,
    output logic [CW-1:0]  grant_idx,
    output logic           any
);

    logic found;
    int   idx;

    assign any = |req;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        if (mode) begin
            for (int i = 0; i < NCH; i++) begin
                if (req[i] && !found) begin
                    found     = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = CW'(i);
                end
            end
        end else begin
            // Modulo wrap keeps non-power-of-2 channel counts in range.
            for (int k = 1; k <= NCH; k++) begin
                idx = (int'(last_g) + k) % NCH;
                if (req[idx] && !found) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    grant_idx  = CW'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/mux_rr_nw.sv
// N-channel registered mux: arbitrated valid/ready inputs feed one
// output register held until the consumer accepts it.
module mux_rr_nw
    import mux_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int NCH   = 4,
    parameter  int MODE  = 0,
    localparam int CW    = clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [CW-1:0]        out_ch,
    input  logic                 out_ready
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    ch_q, ch_d;
    logic [CW-1:0]    last_q, last_d;

    logic [NCH-1:0]   grant;
    logic [CW-1:0]    grant_idx;
    logic             any;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

    rr_arbiter #(
        .NCH(NCH)
    ) u_arb (
        .req      (in_valid),
        .last_g   (last_q),
        .mode     (MODE == MODE_FIXED),
        .grant    (grant),
        .grant_idx(grant_idx),
        .any      (any)
    );

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_ch    = ch_q;

    // Gating with rst keeps in_ready silent while reset is held.
    assign load_en  = (!out_valid || out_ready) && !rst;
    assign xfer     = load_en && any;
    assign in_ready = grant & {NCH{load_en}};

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            sel_data = sel_data
                     | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ch_d    = ch_q;
        last_d  = last_q;
        unique case (state_q)
            EMPTY: if (xfer) state_d = FULL;
            FULL:  if (out_ready && !xfer) state_d = EMPTY;
        endcase
        if (xfer) begin
            data_d = sel_data;
            ch_d   = grant_idx;
            if (MODE == MODE_RR) last_d = grant_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            ch_q    <= '0;
            last_q  <= CW'(NCH - 1);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: doc/mux_rr_nw.md
# mux_rr_nw

Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshake and selectable round-robin or fixed-priority arbitration. It generalises the 4:1 1-bit select mux of the CPU datapath: selection comes from arbitration among requesting sources rather than external select lines, and the result is held in one output register until the consumer accepts it. It sits between multiple producers (register-file read ports, ALU result, immediate path) and a single consumer bus.

## Interface
- WIDTH, 4, data width per channel (1..32)
- NCH, 4, number of input channels (2..16)
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins)
- CW, derived = max(1, clog2(NCH)), channel-index width; not user-overridden

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  NCH  request from channel i at bit i
- in_data  in  NCH*WIDTH  channel i data at bits [i*WIDTH +: WIDTH]
- in_ready  out  NCH  one-hot or zero; bit i high = channel i word accepted this cycle
- out_valid  out  1  output register holds a word
- out_data  out  WIDTH  held word
- out_ch  out  CW  index of channel that supplied out_data
- out_ready  in  1  consumer accepts word when out_valid & out_ready

## Operation
- Two states, encoded by out_valid: EMPTY (0), FULL (1).
- load_en = !out_valid | out_ready.
- Grant computed combinationally from in_valid each cycle; in_ready = grant one-hot gated by load_en. in_ready may depend on in_valid; producers must not make in_valid depend on in_ready.
- Transfer on channel i when in_valid[i] & in_ready[i]: out_data <= channel i data, out_ch <= i, out_valid <= 1.
- load_en with no in_valid: out_valid <= 0 (drain to EMPTY); out_data/out_ch hold last values.
- !load_en: all registers hold; in_ready = 0.
- Round-robin (MODE 0): pointer last_g (CW bits) = last granted channel; search order last_g+1, last_g+2, ... wrapping modulo NCH (correct for non-power-of-2 NCH, e.g. NCH=3 wraps 2->0). last_g updates only on a transfer.
- Fixed priority (MODE 1): lowest-index valid channel wins; last_g unused, held at reset value.
- Transitions: EMPTY -> FULL on transfer; FULL -> FULL on out_ready with transfer, or !out_ready (stall); FULL -> EMPTY on out_ready without request.

## Timing
- Reset (asynchronous assert, removal synchronous to clk): out_valid=0, out_data=0, out_ch=0, last_g=NCH-1 (so channel 0 wins first in RR). in_ready is combinational: with out_valid=0 after reset it follows the grant immediately.
- Latency: input transfer at edge n -> out_valid/out_data visible after edge n.
- Throughput: one word per cycle with out_ready held high.
- Stall: out_data, out_ch stable while out_valid & !out_ready.
- Simultaneous drain and load in same cycle: no bubble.
- Reset mid-operation: held word discarded, pointer restored; no in_ready pulse during rst.
- out_ready while EMPTY: no effect.
- Single requester in RR: granted every cycle, no idle gaps.

## Structure
- Package mux_pkg: MODE_RR=0, MODE_FIXED=1 constants; clog2 function for CW.
- One sub-module: rr_arbiter (inputs req[NCH], last_g[CW], mode; outputs grant one-hot[NCH], grant_idx[CW], any). Purely combinational; mux_rr_nw owns all registers and the pointer.
- Data selection: AND-OR of in_data slices with grant one-hot.

## Test plan
- Reset: assert rst mid-run with out_valid=1 -> out_valid=0, out_data=0, out_ch=0 immediately; after release, all in_valid=1, out_ready=1 -> first out_ch=0.
- RR fairness: NCH=4, WIDTH=4, all valid, data ch i = 4'hA+i, out_ready=1 -> out_ch sequence 0,1,2,3,0 with out_data A,B,C,D,A, one per cycle.
- Fixed priority: MODE=1, in_valid=4'b1010 -> out_ch=1 every cycle, in_ready=4'b0010; drop ch1 -> out_ch=3.
- Backpressure: out_ready=0 for 3 cycles with all valid -> out_data held, in_ready=0; out_ready=1 -> next word from next RR channel, no skip or duplicate.
- Non-power-of-2 wrap: NCH=3, in_valid=3'b101, last_g=2 -> grants 0,2,0,2; out_ch never 3.
- Drain: one word then in_valid=0, out_ready=1 -> out_valid 1 for one cycle then 0, out_data retains last value.
